// File: rtl/pic_ctrl_pkg.sv
// Shared encodings for the PIC16C57 control unit: sequencer states, decoded strobe
// bundle, opcode match/mask pairs and the special file-register addresses.
package pic_ctrl_pkg;

  localparam int INSTR_W = 12;
  localparam logic [4:0] PCL_ADDR   = 5'h02;
  localparam logic [4:0] TRISA_ADDR = 5'h05;
  localparam logic [4:0] TRISB_ADDR = 5'h06;
  localparam logic [4:0] TRISC_ADDR = 5'h07;

  typedef enum logic [2:0] {
    S_RST, S_PRIME, S_EXEC, S_FLUSH, S_SLEEP
  } state_t;

  typedef struct packed {
    logic load_pc_lit, load_stk1_to_pc, pch8_sel;
    logic load_from_pc, load_from_stk1, load_from_stk2;
    logic load_w, write, en_addr;
    logic load_c, load_z, load_dc;
    logic load_trisa, load_trisb, load_trisc, load_option;
    logic load_to, load_pd, set_to, set_pd, clr_wdt;
  } strobe_t;

  // Instruction class bits that steer the sequencer rather than the datapath.
  typedef struct packed {
    logic branch, skip, sleep, pcl_wr;
  } cls_t;

  localparam logic [INSTR_W-1:0] MSK_FOP   = 12'hFC0;
  localparam logic [INSTR_W-1:0] OP_CLR    = 12'h040;
  localparam logic [INSTR_W-1:0] OP_SUBWF  = 12'h080;
  localparam logic [INSTR_W-1:0] OP_DECF   = 12'h0C0;
  localparam logic [INSTR_W-1:0] OP_IORWF  = 12'h100;
  localparam logic [INSTR_W-1:0] OP_ANDWF  = 12'h140;
  localparam logic [INSTR_W-1:0] OP_XORWF  = 12'h180;
  localparam logic [INSTR_W-1:0] OP_ADDWF  = 12'h1C0;
  localparam logic [INSTR_W-1:0] OP_MOVF   = 12'h200;
  localparam logic [INSTR_W-1:0] OP_COMF   = 12'h240;
  localparam logic [INSTR_W-1:0] OP_INCF   = 12'h280;
  localparam logic [INSTR_W-1:0] OP_DECFSZ = 12'h2C0;
  localparam logic [INSTR_W-1:0] OP_RRF    = 12'h300;
  localparam logic [INSTR_W-1:0] OP_RLF    = 12'h340;
  localparam logic [INSTR_W-1:0] OP_SWAPF  = 12'h380;
  localparam logic [INSTR_W-1:0] OP_INCFSZ = 12'h3C0;

  localparam logic [INSTR_W-1:0] MSK_MOVWF = 12'hFE0;
  localparam logic [INSTR_W-1:0] OP_MOVWF  = 12'h020;

  localparam logic [INSTR_W-1:0] MSK_HI4   = 12'hF00;
  localparam logic [INSTR_W-1:0] OP_BCF    = 12'h400;
  localparam logic [INSTR_W-1:0] OP_BSF    = 12'h500;
  localparam logic [INSTR_W-1:0] OP_BTFSC  = 12'h600;
  localparam logic [INSTR_W-1:0] OP_BTFSS  = 12'h700;
  localparam logic [INSTR_W-1:0] OP_RETLW  = 12'h800;
  localparam logic [INSTR_W-1:0] OP_CALL   = 12'h900;
  localparam logic [INSTR_W-1:0] OP_MOVLW  = 12'hC00;
  localparam logic [INSTR_W-1:0] OP_IORLW  = 12'hD00;
  localparam logic [INSTR_W-1:0] OP_ANDLW  = 12'hE00;
  localparam logic [INSTR_W-1:0] OP_XORLW  = 12'hF00;

  localparam logic [INSTR_W-1:0] MSK_GOTO  = 12'hE00;
  localparam logic [INSTR_W-1:0] OP_GOTO   = 12'hA00;

  localparam logic [INSTR_W-1:0] MSK_FULL  = 12'hFFF;
  localparam logic [INSTR_W-1:0] OP_OPTION = 12'h002;
  localparam logic [INSTR_W-1:0] OP_SLEEP  = 12'h003;
  localparam logic [INSTR_W-1:0] OP_CLRWDT = 12'h004;
  localparam logic [INSTR_W-1:0] MSK_TRIS  = 12'hFE0;
  localparam logic [INSTR_W-1:0] OP_TRIS   = 12'h000;

  function automatic logic is_op(input logic [INSTR_W-1:0] ins,
                                 input logic [INSTR_W-1:0] match,
                                 input logic [INSTR_W-1:0] mask);
    return (ins & mask) == match;
  endfunction

endpackage

// File: rtl/pic_decode.sv
// Pure combinational opcode decoder: instruction word -> datapath strobes plus
// the branch/skip/sleep/PCL-write class bits consumed by the sequencer.
module pic_decode
  import pic_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output strobe_t            strobe_o,
  output cls_t               cls_o
);

  logic       d;
  logic [4:0] f;
  logic       clr_op, alu_op, z_op, c_op, dc_op;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    strobe_o = '0;
    cls_o    = '0;
    d        = instr_i[5];
    f        = instr_i[4:0];

    // CLRW exists only as 0x040; other d=0 encodings in that row are undefined.
    clr_op = is_op(instr_i, OP_CLR, MSK_FOP) && (d || f == 5'd0);
    z_op   = is_op(instr_i, OP_ADDWF, MSK_FOP) || is_op(instr_i, OP_SUBWF, MSK_FOP) ||
             is_op(instr_i, OP_ANDWF, MSK_FOP) || is_op(instr_i, OP_IORWF, MSK_FOP) ||
             is_op(instr_i, OP_XORWF, MSK_FOP) || is_op(instr_i, OP_COMF,  MSK_FOP) ||
             is_op(instr_i, OP_INCF,  MSK_FOP) || is_op(instr_i, OP_DECF,  MSK_FOP) ||
             is_op(instr_i, OP_MOVF,  MSK_FOP) || clr_op;
    c_op   = is_op(instr_i, OP_ADDWF, MSK_FOP) || is_op(instr_i, OP_SUBWF, MSK_FOP) ||
             is_op(instr_i, OP_RRF,   MSK_FOP) || is_op(instr_i, OP_RLF,   MSK_FOP);
    dc_op  = is_op(instr_i, OP_ADDWF, MSK_FOP) || is_op(instr_i, OP_SUBWF, MSK_FOP);
    alu_op = z_op || c_op || is_op(instr_i, OP_SWAPF,  MSK_FOP) ||
             is_op(instr_i, OP_DECFSZ, MSK_FOP) || is_op(instr_i, OP_INCFSZ, MSK_FOP);

    if (alu_op) begin
      strobe_o.load_w  = !d;
      strobe_o.write   = d;
      strobe_o.en_addr = d;
      strobe_o.load_z  = z_op;
      strobe_o.load_c  = c_op;
      strobe_o.load_dc = dc_op;
      cls_o.pcl_wr     = d && (f == PCL_ADDR);
    end

    if (is_op(instr_i, OP_MOVWF, MSK_MOVWF)) begin
      strobe_o.write = 1'b1;
      cls_o.pcl_wr   = (f == PCL_ADDR);
    end

    if (is_op(instr_i, OP_BCF, MSK_HI4) || is_op(instr_i, OP_BSF, MSK_HI4))
      strobe_o.write = 1'b1;

    cls_o.skip = is_op(instr_i, OP_DECFSZ, MSK_FOP) || is_op(instr_i, OP_INCFSZ, MSK_FOP) ||
                 is_op(instr_i, OP_BTFSC,  MSK_HI4) || is_op(instr_i, OP_BTFSS,  MSK_HI4);

    if (is_op(instr_i, OP_MOVLW, MSK_HI4))
      strobe_o.load_w = 1'b1;
    if (is_op(instr_i, OP_IORLW, MSK_HI4) || is_op(instr_i, OP_ANDLW, MSK_HI4) ||
        is_op(instr_i, OP_XORLW, MSK_HI4)) begin
      strobe_o.load_w = 1'b1;
      strobe_o.load_z = 1'b1;
    end

    if (is_op(instr_i, OP_GOTO, MSK_GOTO)) begin
      strobe_o.load_pc_lit = 1'b1;
      cls_o.branch         = 1'b1;
    end
    // A push shifts the two-level stack: stk2 <= stk1, stk1 <= PC.
    if (is_op(instr_i, OP_CALL, MSK_HI4)) begin
      strobe_o.load_from_pc   = 1'b1;
      strobe_o.load_from_stk1 = 1'b1;
      strobe_o.load_pc_lit    = 1'b1;
      strobe_o.pch8_sel       = 1'b1;
      cls_o.branch            = 1'b1;
    end
    if (is_op(instr_i, OP_RETLW, MSK_HI4)) begin
      strobe_o.load_w          = 1'b1;
      strobe_o.load_stk1_to_pc = 1'b1;
      strobe_o.load_from_stk2  = 1'b1;
      cls_o.branch             = 1'b1;
    end

    if (is_op(instr_i, OP_OPTION, MSK_FULL))
      strobe_o.load_option = 1'b1;
    if (is_op(instr_i, OP_TRIS, MSK_TRIS)) begin
      strobe_o.load_trisa = (f == TRISA_ADDR);
      strobe_o.load_trisb = (f == TRISB_ADDR);
      strobe_o.load_trisc = (f == TRISC_ADDR);
    end
    if (is_op(instr_i, OP_CLRWDT, MSK_FULL)) begin
      strobe_o.clr_wdt = 1'b1;
      strobe_o.load_to = 1'b1;
      strobe_o.load_pd = 1'b1;
      strobe_o.set_to  = 1'b1;
      strobe_o.set_pd  = 1'b1;
    end
    if (is_op(instr_i, OP_SLEEP, MSK_FULL)) begin
      strobe_o.clr_wdt = 1'b1;
      strobe_o.load_to = 1'b1;
      strobe_o.set_to  = 1'b1;
      strobe_o.load_pd = 1'b1;
      cls_o.sleep      = 1'b1;
    end
  end

endmodule

// File: rtl/pic_control_unit.sv
// Instruction-cycle sequencer for the PIC16C57 core: overlaps fetch and execute and
// inserts one flush cycle after branches, taken skips and writes to PCL.
module pic_control_unit
  import pic_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               POR,
  input  logic [INSTR_W-1:0] instr,
  input  logic               test,
  output logic               load_ins,
  output logic               sel_code,
  output logic               Inc_PC,
  output logic               load_PC_from_Literal,
  output logic               load_stk1_to_PC,
  output logic               PCH8_mux_sel,
  output logic               load_from_PC,
  output logic               load_from_stk1,
  output logic               load_from_stk2,
  output logic               load_W,
  output logic               write,
  output logic               en_addr,
  output logic               load_C,
  output logic               load_Z,
  output logic               load_DC,
  output logic               load_TRISA,
  output logic               load_TRISB,
  output logic               load_TRISC,
  output logic               load_OPTION,
  output logic               load_TO,
  output logic               load_PD,
  output logic               set_TO,
  output logic               set_PD,
  output logic               clr_wdt
);

  state_t  state_q, state_d;
  strobe_t dec;
  strobe_t strb;
  cls_t    cls;

  pic_decode u_decode (
    .instr_i  (instr),
    .strobe_o (dec),
    .cls_o    (cls)
  );

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   if (!POR) state_d = S_PRIME;
      S_PRIME: state_d = S_EXEC;
      S_EXEC: begin
        if (cls.sleep)                                     state_d = S_SLEEP;
        else if (cls.branch || cls.pcl_wr || (cls.skip && test)) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_EXEC;
      S_SLEEP: state_d = S_SLEEP;
      default: state_d = S_RST;
    endcase
  end

  // Only S_EXEC lets decoded strobes through; the flushed IR content is discarded.
  always_comb begin
    strb     = '0;
    sel_code = 1'b0;
    load_ins = 1'b0;
    Inc_PC   = 1'b0;
    case (state_q)
      S_RST: sel_code = 1'b1;
      S_PRIME, S_FLUSH: begin
        load_ins = 1'b1;
        Inc_PC   = 1'b1;
      end
      S_EXEC: begin
        load_ins = 1'b1;
        Inc_PC   = !cls.branch;
        strb     = dec;
      end
      default: ;
    endcase
  end

  assign load_PC_from_Literal = strb.load_pc_lit;
  assign load_stk1_to_PC      = strb.load_stk1_to_pc;
  assign PCH8_mux_sel         = strb.pch8_sel;
  assign load_from_PC         = strb.load_from_pc;
  assign load_from_stk1       = strb.load_from_stk1;
  assign load_from_stk2       = strb.load_from_stk2;
  assign load_W               = strb.load_w;
  assign write                = strb.write;
  assign en_addr              = strb.en_addr;
  assign load_C               = strb.load_c;
  assign load_Z               = strb.load_z;
  assign load_DC              = strb.load_dc;
  assign load_TRISA           = strb.load_trisa;
  assign load_TRISB           = strb.load_trisb;
  assign load_TRISC           = strb.load_trisc;
  assign load_OPTION          = strb.load_option;
  assign load_TO              = strb.load_to;
  assign load_PD              = strb.load_pd;
  assign set_TO               = strb.set_to;
  assign set_PD               = strb.set_pd;
  assign clr_wdt              = strb.clr_wdt;

endmodule

// File: tb/tb_pic_control_unit.sv
// Directed bench for pic_control_unit: table of single-instruction vectors, each
// followed by a probe cycle that shows whether a flush was inserted.
module tb_pic_control_unit;

  logic        clk = 1'b0;
  logic        rst_n, POR, test;
  logic [11:0] instr;
  logic load_ins, sel_code, Inc_PC, load_PC_from_Literal, load_stk1_to_PC, PCH8_mux_sel;
  logic load_from_PC, load_from_stk1, load_from_stk2, load_W, write, en_addr;
  logic load_C, load_Z, load_DC, load_TRISA, load_TRISB, load_TRISC, load_OPTION;
  logic load_TO, load_PD, set_TO, set_PD, clr_wdt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pic_control_unit dut (
    .clk(clk), .rst_n(rst_n), .POR(POR), .instr(instr), .test(test),
    .load_ins(load_ins), .sel_code(sel_code), .Inc_PC(Inc_PC),
    .load_PC_from_Literal(load_PC_from_Literal), .load_stk1_to_PC(load_stk1_to_PC),
    .PCH8_mux_sel(PCH8_mux_sel), .load_from_PC(load_from_PC),
    .load_from_stk1(load_from_stk1), .load_from_stk2(load_from_stk2),
    .load_W(load_W), .write(write), .en_addr(en_addr),
    .load_C(load_C), .load_Z(load_Z), .load_DC(load_DC),
    .load_TRISA(load_TRISA), .load_TRISB(load_TRISB), .load_TRISC(load_TRISC),
    .load_OPTION(load_OPTION), .load_TO(load_TO), .load_PD(load_PD),
    .set_TO(set_TO), .set_PD(set_PD), .clr_wdt(clr_wdt)
  );

  localparam logic [23:0] O_SEL    = 24'd1 << 23;
  localparam logic [23:0] O_LI     = 24'd1 << 22;
  localparam logic [23:0] O_IP     = 24'd1 << 21;
  localparam logic [23:0] O_LIT    = 24'd1 << 20;
  localparam logic [23:0] O_STK1PC = 24'd1 << 19;
  localparam logic [23:0] O_PCH8   = 24'd1 << 18;
  localparam logic [23:0] O_FPC    = 24'd1 << 17;
  localparam logic [23:0] O_FSTK1  = 24'd1 << 16;
  localparam logic [23:0] O_FSTK2  = 24'd1 << 15;
  localparam logic [23:0] O_LW     = 24'd1 << 14;
  localparam logic [23:0] O_WR     = 24'd1 << 13;
  localparam logic [23:0] O_EA     = 24'd1 << 12;
  localparam logic [23:0] O_LC     = 24'd1 << 11;
  localparam logic [23:0] O_LZ     = 24'd1 << 10;
  localparam logic [23:0] O_LDC    = 24'd1 << 9;
  localparam logic [23:0] O_TA     = 24'd1 << 8;
  localparam logic [23:0] O_TB     = 24'd1 << 7;
  localparam logic [23:0] O_TC     = 24'd1 << 6;
  localparam logic [23:0] O_OPT    = 24'd1 << 5;
  localparam logic [23:0] O_LTO    = 24'd1 << 4;
  localparam logic [23:0] O_LPD    = 24'd1 << 3;
  localparam logic [23:0] O_STO    = 24'd1 << 2;
  localparam logic [23:0] O_SPD    = 24'd1 << 1;
  localparam logic [23:0] O_WDT    = 24'd1 << 0;

  localparam logic [23:0] EX     = O_LI | O_IP;
  localparam logic [23:0] ADD_F  = EX | O_WR | O_EA | O_LZ | O_LC | O_LDC;
  localparam logic [23:0] GOTO_V = O_LI | O_LIT;
  localparam logic [23:0] CALL_V = O_LI | O_LIT | O_PCH8 | O_FPC | O_FSTK1;
  localparam logic [23:0] RET_V  = O_LI | O_LW | O_STK1PC | O_FSTK2;

  logic [23:0] out_vec;
  assign out_vec = {sel_code, load_ins, Inc_PC, load_PC_from_Literal, load_stk1_to_PC,
                    PCH8_mux_sel, load_from_PC, load_from_stk1, load_from_stk2,
                    load_W, write, en_addr, load_C, load_Z, load_DC,
                    load_TRISA, load_TRISB, load_TRISC, load_OPTION,
                    load_TO, load_PD, set_TO, set_PD, clr_wdt};

  typedef struct {
    string       name;
    logic [11:0] instr;
    logic        test;
    logic [23:0] exp;
    logic        flush;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic [11:0] ins, input logic t,
                     input logic [23:0] exp, input logic fl);
    vec_t v;
    v.name = name; v.instr = ins; v.test = t; v.exp = exp; v.flush = fl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  // Sample just after the falling-edge drive, well clear of the rising edge.
  task automatic sample(input string name, input logic [23:0] exp);
    int pc_src;
    #1;
    check(name, out_vec, exp);
    pc_src = int'(Inc_PC) + int'(load_PC_from_Literal) + int'(load_stk1_to_PC);
    checks++;
    if (pc_src > 1) begin
      errors++;
      $display("FAIL %s_pc_onehot: got %0d PC sources expected at most 1", name, pc_src);
    end
  endtask

  task automatic restart();
    @(negedge clk);
    rst_n = 1'b1; POR = 1'b0; instr = 12'h1F0; test = 1'b0;
    @(negedge clk);
    sample("restart_prime", EX);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; POR = 1'b1; instr = 12'h1F0; test = 1'b1;

    add("addwf_f",     12'h1F0, 1'b0, ADD_F, 1'b0);
    add("addwf_w_t1",  12'h1D0, 1'b1, EX | O_LW | O_LZ | O_LC | O_LDC, 1'b0);
    add("subwf_f",     12'h0B0, 1'b0, ADD_F, 1'b0);
    add("rrf_f",       12'h330, 1'b0, EX | O_WR | O_EA | O_LC, 1'b0);
    add("swapf_w",     12'h390, 1'b0, EX | O_LW, 1'b0);
    add("movf_w",      12'h210, 1'b0, EX | O_LW | O_LZ, 1'b0);
    add("clrf",        12'h070, 1'b0, EX | O_WR | O_EA | O_LZ, 1'b0);
    add("clrw",        12'h040, 1'b0, EX | O_LW | O_LZ, 1'b0);
    add("movwf",       12'h030, 1'b0, EX | O_WR, 1'b0);
    add("movwf_pcl",   12'h022, 1'b0, EX | O_WR, 1'b1);
    add("subwf_pcl_f", 12'h0A2, 1'b0, ADD_F, 1'b1);
    add("subwf_pcl_w", 12'h082, 1'b0, EX | O_LW | O_LZ | O_LC | O_LDC, 1'b0);
    add("movlw",       12'hC55, 1'b0, EX | O_LW, 1'b0);
    add("andlw",       12'hE0F, 1'b0, EX | O_LW | O_LZ, 1'b0);
    add("bsf",         12'h510, 1'b0, EX | O_WR, 1'b0);
    add("btfss_t1",    12'h710, 1'b1, EX, 1'b1);
    add("btfss_t0",    12'h710, 1'b0, EX, 1'b0);
    add("decfsz_t1",   12'h2D0, 1'b1, EX | O_LW, 1'b1);
    add("incfsz_t0",   12'h3F0, 1'b0, EX | O_WR | O_EA, 1'b0);
    add("goto",        12'hB55, 1'b0, GOTO_V, 1'b1);
    add("call",        12'h920, 1'b0, CALL_V, 1'b1);
    add("retlw",       12'h855, 1'b0, RET_V, 1'b1);
    add("option",      12'h002, 1'b0, EX | O_OPT, 1'b0);
    add("tris_a",      12'h005, 1'b0, EX | O_TA, 1'b0);
    add("tris_b",      12'h006, 1'b0, EX | O_TB, 1'b0);
    add("tris_c",      12'h007, 1'b0, EX | O_TC, 1'b0);
    add("undef_001",   12'h001, 1'b0, EX, 1'b0);
    add("clrwdt",      12'h004, 1'b0, EX | O_WDT | O_LTO | O_LPD | O_STO | O_SPD, 1'b0);
    add("nop",         12'h000, 1'b0, EX, 1'b0);

    // Reset, POR hold, then prime.
    #2;
    sample("reset_async", O_SEL);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    sample("por_hold", O_SEL);
    POR = 1'b0; test = 1'b0;
    @(negedge clk);
    sample("prime", EX);

    foreach (vecs[i]) begin
      @(negedge clk);
      instr = vecs[i].instr; test = vecs[i].test;
      sample(vecs[i].name, vecs[i].exp);
      @(negedge clk);
      instr = 12'h1F0; test = 1'b0;
      sample({vecs[i].name, "_next"}, vecs[i].flush ? EX : ADD_F);
    end

    // Reset asserted during a flush cycle.
    @(negedge clk); instr = 12'hB55;
    sample("goto_pre_rst", GOTO_V);
    @(negedge clk); instr = 12'h1F0;
    sample("flush_pre_rst", EX);
    rst_n = 1'b0;
    sample("rst_mid_flush", O_SEL);
    restart();

    // Reset asserted while CALL is executing: its push strobes must vanish at once.
    @(negedge clk); instr = 12'h920;
    sample("call_pre_rst", CALL_V);
    rst_n = 1'b0;
    sample("rst_mid_call", O_SEL);
    @(negedge clk);
    sample("rst_hold", O_SEL);
    restart();

    // SLEEP, then everything frozen until rst_n.
    @(negedge clk); instr = 12'h003;
    sample("sleep_exec", EX | O_WDT | O_LTO | O_STO | O_LPD);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      instr = (i % 2 == 0) ? 12'h1F0 : 12'hB55;
      test  = 1'b1;
      sample("sleep_hold", 24'd0);
    end
    rst_n = 1'b0;
    sample("sleep_rst", O_SEL);
    restart();
    @(negedge clk); instr = 12'h1F0;
    sample("post_sleep_exec", ADD_F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
